// File: rtl/inst_encoder_loader.sv
// Encodes symbolic instruction beats into 32-bit MIPS words and streams them
// through a small FIFO into instruction memory at consecutive word addresses.
module inst_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 4,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              err_illegal,
  output logic              err_wrap,
  output logic [ADDR_W:0]   words_written
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]    FULL_CNT = DEPTH[PTR_W:0];
  localparam logic [ADDR_W-1:0] BASE     = BASE_ADDR[ADDR_W-1:0];

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic [31:0]       r_fifo [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [PTR_W:0]    r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_words;
  logic              r_done;
  logic              r_err_ill;
  logic              r_err_wrap;

  logic        w_full;
  logic        w_empty;
  logic        w_active;
  logic        w_accept;
  logic        w_legal;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_word;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_legal  = (in_op <= 4'd10);
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && w_legal;
  assign w_pop    = mem_we && mem_ready;

  assign in_ready      = (r_state == S_RUN) && !w_full;
  assign mem_we        = w_active && !w_empty;
  assign mem_wdata     = mem_we ? r_fifo[r_rptr] : 32'h0;
  assign mem_addr      = r_addr;
  assign done          = r_done;
  assign err_illegal   = r_err_ill;
  assign err_wrap      = r_err_wrap;
  assign words_written = r_words;

  // Shifts take their source from rt, so the rs slot is zeroed for SLL/SRL.
  always_comb begin
    w_word = 32'h0;
    case (in_op)
      4'd0:  w_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0,     6'b100000};
      4'd1:  w_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0,     6'b100100};
      4'd2:  w_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0,     6'b100101};
      4'd3:  w_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0,     6'b100110};
      4'd4:  w_word = {6'b000000, 5'd0,  in_rt, in_rd, in_shamt, 6'b000000};
      4'd5:  w_word = {6'b000000, 5'd0,  in_rt, in_rd, in_shamt, 6'b000010};
      4'd6:  w_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0,     6'b100010};
      4'd7:  w_word = {6'b101011, in_rs, in_rt, in_imm};
      4'd8:  w_word = {6'b100011, in_rs, in_rt, in_imm};
      4'd9:  w_word = {6'b000100, in_rs, in_rt, in_imm};
      4'd10: w_word = {6'b001000, in_rs, in_rt, in_imm};
      default: w_word = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= w_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_addr     <= BASE;
      r_words    <= '0;
      r_done     <= 1'b0;
      r_err_ill  <= 1'b0;
      r_err_wrap <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_RUN;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_addr     <= BASE;
            r_words    <= '0;
            r_done     <= 1'b0;
            r_err_ill  <= 1'b0;
            r_err_wrap <= 1'b0;
          end
        end
        S_RUN, S_DRAIN: begin
          if (w_push) r_wptr <= r_wptr + 1'b1;
          if (w_pop) begin
            r_rptr  <= r_rptr + 1'b1;
            r_addr  <= r_addr + 1'b1;
            r_words <= r_words + 1'b1;
            if (&r_addr) r_err_wrap <= 1'b1;
          end
          r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
          if (w_accept && !w_legal) r_err_ill <= 1'b1;
          // Only RUN accepts beats, so an empty FIFO in DRAIN means every write landed.
          if (r_state == S_RUN) begin
            if (w_accept && in_last) r_state <= S_DRAIN;
          end else if (w_empty) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Self-checking bench: two loaders (ADDR_W=8 and ADDR_W=2) share one stimulus
// stream; writes are scoreboarded against an arithmetic encoding model.
module tb_inst_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, in_valid, in_last, mem_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;

  logic        in_ready, mem_we, done, err_illegal, err_wrap;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  words_written;

  logic        in_ready1, mem_we1, done1, err_illegal1, err_wrap1;
  logic [1:0]  mem_addr1;
  logic [31:0] mem_wdata1;
  logic [2:0]  words_written1;

  always #5 clk = ~clk;

  inst_encoder_loader #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done), .err_illegal(err_illegal),
    .err_wrap(err_wrap), .words_written(words_written));

  inst_encoder_loader #(.ADDR_W(2), .DEPTH(4), .BASE_ADDR(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready1),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we1), .mem_ready(mem_ready),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .done(done1), .err_illegal(err_illegal1),
    .err_wrap(err_wrap1), .words_written(words_written1));

  typedef struct {
    int          addr;
    int unsigned data;
    int          cyc;
  } wr_t;

  typedef struct {
    int          op, rs, rt, rd, sh, imm;
    int unsigned exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_ill = 0;
  bit rnd_ready = 0;
  wr_t got0[$];
  wr_t got1[$];
  int unsigned exp_w[$];
  wr_t mw;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned model_enc(int op, int rs, int rt, int rd, int sh, int imm);
    int unsigned funct_tab[7] = '{32, 36, 37, 38, 0, 2, 34};
    int unsigned opc_tab[4]   = '{43, 35, 4, 8};
    int unsigned w;
    if (op <= 6) begin
      w = funct_tab[op] + (rd << 11) + (rt << 16);
      if (op == 4 || op == 5) w = w + (sh << 6);
      else w = w + (rs << 21);
    end else begin
      w = (opc_tab[op-7] << 26) + (rs << 21) + (rt << 16) + imm;
    end
    return w;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we && mem_ready) begin
        mw.addr = int'(mem_addr); mw.data = mem_wdata; mw.cyc = cyc;
        got0.push_back(mw);
      end
      if (mem_we1 && mem_ready) begin
        mw.addr = int'(mem_addr1); mw.data = mem_wdata1; mw.cyc = cyc;
        got1.push_back(mw);
      end
      if (in_valid && in_ready) begin
        if (in_op <= 4'd10)
          exp_w.push_back(model_enc(int'(in_op), int'(in_rs), int'(in_rt), int'(in_rd),
                                    int'(in_shamt), int'(in_imm)));
        else
          n_ill++;
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) mem_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic set_beat(input int op, input int rs, input int rt, input int rd,
                          input int sh, input int imm, input bit last);
    in_valid = 1'b1;
    in_op    = 4'(op);
    in_rs    = 5'(rs);
    in_rt    = 5'(rt);
    in_rd    = 5'(rd);
    in_shamt = 5'(sh);
    in_imm   = 16'(imm);
    in_last  = last;
  endtask

  task automatic send_beat(input int op, input int rs, input int rt, input int rd,
                           input int sh, input int imm, input bit last);
    int n = 0;
    set_beat(op, rs, rt, rd, sh, imm, last);
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk("done_reached", done, 1);
  endtask

  task automatic do_start();
    exp_w.delete();
    got0.delete();
    got1.delete();
    n_ill = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_session();
    int n = exp_w.size();
    chk("n_writes0", got0.size(), n);
    chk("n_writes1", got1.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got0.size()) begin
        chk($sformatf("wdata0[%0d]", i), got0[i].data, exp_w[i]);
        chk($sformatf("addr0[%0d]", i), got0[i].addr, i % 256);
      end
      if (i < got1.size()) begin
        chk($sformatf("wdata1[%0d]", i), got1[i].data, exp_w[i]);
        chk($sformatf("addr1[%0d]", i), got1[i].addr, i % 4);
      end
    end
    chk("words_written0", words_written, n);
    chk("words_written1", words_written1, n % 8);
    chk("err_illegal0", err_illegal, (n_ill > 0) ? 1 : 0);
    chk("err_wrap0", err_wrap, (n >= 256) ? 1 : 0);
    chk("err_wrap1", err_wrap1, (n >= 4) ? 1 : 0);
    chk("done1", done1, 1);
  endtask

  vec_t vt[11];

  initial begin
    vt[0]  = '{op: 8,  rs: 29, rt: 8,  rd: 0,  sh: 0,  imm: 4,      exp: 32'h8FA80004};
    vt[1]  = '{op: 7,  rs: 29, rt: 8,  rd: 0,  sh: 0,  imm: 8,      exp: 32'hAFA80008};
    vt[2]  = '{op: 9,  rs: 4,  rt: 5,  rd: 0,  sh: 0,  imm: 'hFFFF, exp: 32'h1085FFFF};
    vt[3]  = '{op: 10, rs: 0,  rt: 1,  rd: 5,  sh: 7,  imm: 5,      exp: 32'h20010005};
    vt[4]  = '{op: 0,  rs: 1,  rt: 2,  rd: 3,  sh: 3,  imm: 0,      exp: 32'h00221820};
    vt[5]  = '{op: 1,  rs: 1,  rt: 2,  rd: 3,  sh: 0,  imm: 0,      exp: 32'h00221824};
    vt[6]  = '{op: 2,  rs: 1,  rt: 2,  rd: 3,  sh: 0,  imm: 0,      exp: 32'h00221825};
    vt[7]  = '{op: 3,  rs: 1,  rt: 2,  rd: 3,  sh: 0,  imm: 0,      exp: 32'h00221826};
    vt[8]  = '{op: 6,  rs: 1,  rt: 2,  rd: 3,  sh: 0,  imm: 0,      exp: 32'h00221822};
    vt[9]  = '{op: 4,  rs: 7,  rt: 9,  rd: 10, sh: 2,  imm: 0,      exp: 32'h00095080};
    vt[10] = '{op: 5,  rs: 7,  rt: 9,  rd: 10, sh: 2,  imm: 0,      exp: 32'h00095082};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; mem_ready = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_err_illegal", err_illegal, 0);
    chk("rst_err_wrap", err_wrap, 0);
    chk("rst_words", words_written, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // single ADD, first-write latency
    mem_ready = 1'b1;
    do_start();
    send_beat(0, 1, 2, 3, 0, 0, 1);
    chk("latency_mem_we", mem_we, 1);
    chk("latency_addr", mem_addr, 0);
    chk("latency_wdata", mem_wdata, 32'h00221820);
    wait_done(50);
    check_session();
    chk("single_words", words_written, 1);

    // table session, back-to-back, first four must write on consecutive cycles
    do_start();
    for (int i = 0; i < 11; i++)
      send_beat(vt[i].op, vt[i].rs, vt[i].rt, vt[i].rd, vt[i].sh, vt[i].imm, i == 10);
    wait_done(100);
    check_session();
    for (int i = 0; i < 11; i++)
      if (i < got0.size()) chk($sformatf("table_word[%0d]", i), got0[i].data, vt[i].exp);
    if (got0.size() >= 4)
      for (int i = 1; i < 4; i++)
        chk($sformatf("burst_gap[%0d]", i), got0[i].cyc - got0[0].cyc, i);
    else
      chk("burst_len", got0.size(), 4);

    // backpressure: 4 accepted, 5th blocked, head held stable
    mem_ready = 1'b0;
    do_start();
    for (int i = 0; i < 4; i++) send_beat(0, 1, 2, i + 4, 0, 0, 0);
    set_beat(2, 3, 4, 8, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_mem_we", mem_we, 1);
      chk("bp_addr", mem_addr, 0);
      chk("bp_wdata", mem_wdata, model_enc(0, 1, 2, 4, 0, 0));
      tick();
    end
    mem_ready = 1'b1;
    send_beat(2, 3, 4, 8, 0, 0, 0);
    send_beat(3, 3, 4, 9, 0, 0, 1);
    wait_done(100);
    check_session();

    // illegal op mid-stream, then cleared by next start; illegal last beat
    do_start();
    send_beat(0, 1, 2, 3, 0, 0, 0);
    send_beat(12, 1, 2, 3, 0, 0, 0);
    send_beat(2, 5, 6, 7, 0, 0, 1);
    wait_done(50);
    check_session();
    chk("illegal_set", err_illegal, 1);
    do_start();
    chk("illegal_cleared", err_illegal, 0);
    chk("done_cleared", done, 0);
    send_beat(13, 0, 0, 0, 0, 0, 1);
    wait_done(50);
    check_session();

    // wrap on the 2-bit instance
    do_start();
    for (int i = 0; i < 5; i++) send_beat(10, 0, i, 0, 0, i, i == 4);
    wait_done(50);
    check_session();
    chk("wrap1_flag", err_wrap1, 1);
    chk("wrap1_words", words_written1, 5);
    chk("wrap0_flag", err_wrap, 0);

    // async reset mid-burst
    mem_ready = 1'b0;
    do_start();
    send_beat(0, 1, 1, 1, 0, 0, 0);
    send_beat(0, 2, 2, 2, 0, 0, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_mem_we", mem_we, 0);
    chk("midrst_mem_we1", mem_we1, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_words", words_written, 0);
    #2 rst_n = 1'b1;
    mem_ready = 1'b1;
    set_beat(0, 1, 2, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_in_ready", in_ready, 0);
      chk("idle_mem_we", mem_we, 0);
    end
    in_valid = 1'b0;

    // randomized sessions with random backpressure, gaps and stray starts
    rnd_ready = 1;
    for (int s = 0; s < 20; s++) begin
      int len = $urandom_range(1, 7);
      do_start();
      for (int b = 0; b < len; b++) begin
        int op;
        int gap = $urandom_range(0, 2);
        repeat (gap) tick();
        if ($urandom_range(0, 7) == 0) begin
          start = 1'b1;
          tick();
          start = 1'b0;
        end
        op = ($urandom_range(0, 9) == 0) ? $urandom_range(11, 15) : $urandom_range(0, 10);
        send_beat(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 65535), b == len - 1);
      end
      wait_done(300);
      check_session();
    end
    rnd_ready = 0;
    mem_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
- Inverse of the core's instruction decoder: takes symbolic instruction beats and encodes them into 32-bit MIPS words.
- Streams the encoded words into instruction memory at consecutive addresses.
- Sits between the testbench/boot loader and the imem write port.
- Includes a small FIFO so the instruction source and the memory write port are decoupled by valid/ready.

Parameters:
ADDR_W, 8, imem word-address width.
DEPTH, 4, FIFO entries (power of 2, >=2).
BASE_ADDR, 0, first word address written after start.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle pulse that begins a load session.
in_valid  input  1  instruction beat valid.
in_ready  output  1  beat accepted when in_valid && in_ready.
in_op  input  4  0 ADD, 1 AND, 2 OR, 3 XOR, 4 SLL, 5 SRL, 6 SUB, 7 SW, 8 LW, 9 BEQ, 10 ADDI, 11-15 illegal.
in_rs  input  5  rs field.
in_rt  input  5  rt field.
in_rd  input  5  rd field.
in_shamt  input  5  shift amount.
in_imm  input  16  immediate.
in_last  input  1  final beat of the session.
mem_we  output  1  write request.
mem_ready  input  1  memory accepts the write when mem_we && mem_ready.
mem_addr  output  ADDR_W  word address.
mem_wdata  output  32  encoded instruction.
done  output  1  high in DONE until the next start.
err_illegal  output  1  sticky: an illegal op was received.
err_wrap  output  1  sticky: the address wrapped past all-ones.
words_written  output  ADDR_W+1  count of completed writes in the current session.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state IDLE, FIFO empty.
  - in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - done=0, err_illegal=0, err_wrap=0, words_written=0.
- Encoding (combinational on the in_* fields, registered into the FIFO on acceptance):
  - R-type ops 0-6: {6'b000000, rs, rt, rd, shamt, funct}.
    - funct: ADD 100000, AND 100100, OR 100101, XOR 100110, SLL 000000, SRL 000010, SUB 100010.
    - SLL/SRL: rs field forced 0, shamt taken from in_shamt.
    - All other R-type ops: shamt field forced 0.
  - I-type: {opcode, rs, rt, imm} with opcode SW 101011, LW 100011, BEQ 000100, ADDI 001000.
  - rd and shamt inputs are ignored for I-type ops.
- Illegal op: the beat is consumed (handshake completes), nothing is pushed, err_illegal set. in_last on an illegal beat is still honoured.
- States:
  - IDLE: in_ready=0; start -> RUN.
  - RUN: in_ready = !fifo_full. An accepted beat with in_last=1 -> DRAIN.
  - DRAIN: in_ready=0; when the FIFO is empty and no write is pending -> DONE.
  - DONE: done=1, in_ready=0; start -> RUN.
- Start:
  - On entering RUN: mem_addr=BASE_ADDR, words_written=0, err_illegal=0, err_wrap=0, done=0, FIFO cleared.
  - start in RUN or DRAIN is ignored.
- Write side (RUN/DRAIN):
  - mem_we = FIFO non-empty; mem_wdata = FIFO head.
  - On mem_we && mem_ready: pop the head, mem_addr increments mod 2^ADDR_W, words_written++.
  - If mem_addr was all-ones at that write, set err_wrap.
  - While mem_we && !mem_ready: mem_addr and mem_wdata hold stable.
- Latency: a beat accepted at cycle N into an empty FIFO drives mem_we at cycle N+1. Sustained throughput is 1 word/cycle with mem_ready=1.
- Simultaneous push and pop on a non-empty, non-full FIFO: occupancy unchanged, order preserved.
- Full FIFO: in_ready=0; no push, even if a pop occurs in the same cycle.
- Reset mid-session: everything returns to reset values immediately; the partially written memory contents are not tracked.

Test Plan:
- start; ADD rs=1 rt=2 rd=3 with in_last=1; mem_ready=1 -> single write, mem_addr=0, mem_wdata=0x00221820, then done=1, words_written=1.
- Back-to-back burst, mem_ready=1:
  - LW rs=29 rt=8 imm=4 -> addr 0, 0x8FA80004.
  - SW rs=29 rt=8 imm=8 -> addr 1, 0xAFA80008.
  - BEQ rs=4 rt=5 imm=0xFFFF -> addr 2, 0x1085FFFF.
  - ADDI rs=0 rt=1 imm=5 (last) -> addr 3, 0x20010005.
  - Expect 4 consecutive write cycles.
- SLL rs=7 rt=9 rd=10 shamt=2 -> 0x00095080 (rs forced 0); ADD with in_shamt=3 -> shamt field 0.
- mem_ready=0 while 6 beats are offered:
  - in_ready drops after 4 accepts; mem_addr/mem_wdata stable throughout.
  - Release mem_ready -> all 6 words written in order; no loss or duplication.
- in_op=12 mid-stream -> err_illegal=1, no write issued for that beat, address not advanced; next session's start clears err_illegal.
- ADDR_W=2, 5 beats -> writes to 0,1,2,3,0; err_wrap=1, words_written=5. Assert rst_n low mid-burst -> mem_we=0, state IDLE immediately.
